// File: rtl/arcfour_encrypt.sv
// RC4 stream encryptor driving external S-box RAM, plaintext ROM and ciphertext RAM.
// Define ARCFOUR_ENCRYPT_DROP_EN to discard the first 256 keystream bytes (RC4-drop256).
module arcfour_encrypt #(
  parameter int RAM_WIDTH          = 8,
  parameter int KEY_LENGTH         = 3,
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key,
  output logic [7:0]                           sAddr,
  output logic [RAM_WIDTH-1:0]                 sIn,
  output logic                                 sWren,
  input  logic [RAM_WIDTH-1:0]                 sOut,
  output logic [MESSAGE_LOG_LENGTH-1:0]        pAddr,
  input  logic [RAM_WIDTH-1:0]                 pOut,
  output logic [MESSAGE_LOG_LENGTH-1:0]        cAddr,
  output logic [RAM_WIDTH-1:0]                 cIn,
  output logic                                 cWren,
  output logic                                 busy,
  output logic                                 done
);
  localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam logic [RAM_WIDTH-1:0] LEN_MAX = RAM_WIDTH'(MESSAGE_LENGTH - 1);

`ifdef ARCFOUR_ENCRYPT_DROP_EN
  typedef enum logic [2:0] {IDLE, LOAD_LEN, INIT, SHUFFLE, DROP, ENCRYPT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD_LEN, INIT, SHUFFLE, ENCRYPT, DONE} state_t;
`endif

  state_t                                state, state_next;
  logic [2:0]                            step;
  logic [7:0]                            i, j;
  logic [RAM_WIDTH-1:0]                  si, sj, pbyte;
  logic [MESSAGE_LOG_LENGTH-1:0]         len, k, len_clamp;
  logic [KW-1:0]                         kidx;
  logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0]  key_reg;
  logic [7:0]                            j_sh, j_en;

  // kidx counts down because key byte b sits at key[KEY_LENGTH-1-b].
  assign j_sh      = j + 8'(sOut) + 8'(key_reg[kidx]);
  assign j_en      = j + 8'(sOut);
  assign len_clamp = MESSAGE_LOG_LENGTH'((pOut > LEN_MAX) ? LEN_MAX : pOut);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = LOAD_LEN;
      LOAD_LEN: if (step == 3'd1) state_next = INIT;
      INIT:     if (i == 8'hFF) state_next = SHUFFLE;
      SHUFFLE:
        if (step == 3'd3 && i == 8'hFF)
`ifdef ARCFOUR_ENCRYPT_DROP_EN
          state_next = DROP;
      DROP:
        if (step == 3'd3 && i == 8'h00) state_next = (len == '0) ? DONE : ENCRYPT;
`else
          state_next = (len == '0) ? DONE : ENCRYPT;
`endif
      ENCRYPT:  if (step == 3'd5 && k == len) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step    <= '0;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      sj      <= '0;
      pbyte   <= '0;
      len     <= '0;
      k       <= '0;
      kidx    <= '0;
      key_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          step <= '0;
          if (start) begin
            key_reg <= key;
            i       <= '0;
            j       <= '0;
            k       <= MESSAGE_LOG_LENGTH'(1);
            kidx    <= KW'(KEY_LENGTH - 1);
          end
        end
        LOAD_LEN: begin
          step <= (step == 3'd1) ? '0 : step + 3'd1;
          if (step == 3'd1) len <= len_clamp;
        end
        INIT: i <= i + 8'd1;
        SHUFFLE: begin
          step <= (step == 3'd3) ? '0 : step + 3'd1;
          case (step)
            3'd1: begin
              si <= sOut;
              j  <= j_sh;
            end
            3'd3: begin
              i    <= i + 8'd1;
              kidx <= (kidx == '0) ? KW'(KEY_LENGTH - 1) : kidx - KW'(1);
              if (i == 8'hFF) j <= '0;
            end
            default: ;
          endcase
        end
`ifdef ARCFOUR_ENCRYPT_DROP_EN
        DROP,
`endif
        ENCRYPT: begin
          // DROP stops after the swap; ENCRYPT continues to the output byte.
          if (step == 3'd5 || (state != ENCRYPT && step == 3'd3)) step <= '0;
          else                                                     step <= step + 3'd1;
          case (step)
            3'd0: i <= i + 8'd1;
            3'd1: begin
              si    <= sOut;
              j     <= j_en;
              pbyte <= pOut;
            end
            3'd2: sj <= sOut;
            3'd5: k  <= k + MESSAGE_LOG_LENGTH'(1);
            default: ;
          endcase
        end
        default: step <= '0;
      endcase
    end
  end

  always_comb begin
    busy  = (state != IDLE) && (state != DONE);
    done  = (state == DONE);
    sAddr = '0;
    sIn   = '0;
    sWren = 1'b0;
    pAddr = '0;
    cAddr = '0;
    cIn   = '0;
    cWren = 1'b0;
    case (state)
      LOAD_LEN:
        if (step == 3'd1) begin
          cIn   = RAM_WIDTH'(len_clamp);
          cWren = 1'b1;
        end
      INIT: begin
        sAddr = i;
        sIn   = RAM_WIDTH'(i);
        sWren = 1'b1;
      end
      SHUFFLE:
        case (step)
          3'd0: sAddr = i;
          3'd1: sAddr = j_sh;
          3'd2: begin
            sAddr = i;
            sIn   = sOut;
            sWren = 1'b1;
          end
          default: begin
            sAddr = j;
            sIn   = si;
            sWren = 1'b1;
          end
        endcase
`ifdef ARCFOUR_ENCRYPT_DROP_EN
      DROP,
`endif
      ENCRYPT:
        // S[j] read in step 1 is written to S[i] in step 2, so i==j leaves S[i] intact.
        case (step)
          3'd0: begin
            sAddr = i + 8'd1;
            pAddr = k;
          end
          3'd1: sAddr = j_en;
          3'd2: begin
            sAddr = i;
            sIn   = sOut;
            sWren = 1'b1;
          end
          3'd3: begin
            sAddr = j;
            sIn   = si;
            sWren = 1'b1;
          end
          3'd4: sAddr = 8'(si) + 8'(sj);
          default: begin
            cAddr = k;
            cIn   = pbyte ^ sOut;
            cWren = 1'b1;
          end
        endcase
      default: ;
    endcase
    if (reset) begin
      sWren = 1'b0;
      cWren = 1'b0;
    end
  end

endmodule

// File: tb/tb_arcfour_encrypt.sv
// Directed-vector bench for arcfour_encrypt with behavioural S-box RAM, plaintext ROM and ciphertext RAM.
module tb_arcfour_encrypt;
  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0][7:0] key;
  logic [7:0]      sAddr, sIn, sOut, pOut, cIn;
  logic            sWren, cWren, busy, done;
  logic [4:0]      pAddr, cAddr;

  always #5 clk = ~clk;

  arcfour_encrypt #(
    .RAM_WIDTH(8), .KEY_LENGTH(3), .MESSAGE_LENGTH(32), .MESSAGE_LOG_LENGTH(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .key(key),
    .sAddr(sAddr), .sIn(sIn), .sWren(sWren), .sOut(sOut),
    .pAddr(pAddr), .pOut(pOut),
    .cAddr(cAddr), .cIn(cIn), .cWren(cWren),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [23:0]     key;
    logic [7:0]      len;
    logic [0:8][7:0] pt;
    logic [0:8][7:0] ct;
    logic [7:0]      c0;
    int              ncheck;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] s_mem[256];
  logic [7:0] p_mem[32];
  logic [7:0] c_mem[32];
  int         c_cnt[32];
  logic [7:0] s_q, p_q;
  int         c_writes, s_writes, done_cnt, overlap;
  logic       clr;
  int         exp_len;
  int         tests = 0;
  int         fails = 0;

  assign sOut = s_q;
  assign pOut = p_q;

  always @(posedge clk) begin
    if (clr) begin
      for (int a = 0; a < 32; a++) begin
        c_mem[a] <= 8'hEE;
        c_cnt[a] <= 0;
      end
      c_writes <= 0;
      done_cnt <= 0;
      overlap  <= 0;
    end else begin
      if (cWren) begin
        c_mem[cAddr] <= cIn;
        c_cnt[cAddr] <= c_cnt[cAddr] + 1;
        c_writes     <= c_writes + 1;
      end
      if (sWren && cWren) overlap <= overlap + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
    if (sWren) begin
      s_mem[sAddr] <= sIn;
      s_writes     <= s_writes + 1;
    end
    s_q <= s_mem[sAddr];
    p_q <= p_mem[pAddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input vec_t v);
    exp_len = (v.len > 8'd31) ? 31 : int'(v.len);
    p_mem[0] = v.len;
    for (int a = 1; a < 32; a++) p_mem[a] = (a <= 9) ? v.pt[a-1] : 8'h00;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit hold, input bit chg, output int cyc, output bit seen);
    int lim;
    load_mem(v);
    lim   = 1798 + 8 * exp_len;
    key   = v.key;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    if (chg) key = 24'h00A5C3;
    cyc = 1;
    while (!done && cyc <= lim) begin
      @(negedge clk);
      cyc++;
    end
    seen = done;
  endtask

  task automatic verify(input vec_t v, input int cyc, input bit seen, input string tag);
    int bad;
    bad = 0;
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(cyc <= 1798 + 8 * exp_len), 32'd1);
    check({tag, " c0"}, 32'(c_mem[0]), 32'(v.c0));
    for (int b = 0; b < v.ncheck; b++)
      check($sformatf("%s c%0d", tag, b + 1), 32'(c_mem[b+1]), 32'(v.ct[b]));
    check({tag, " write_count"}, c_writes, exp_len + 1);
    for (int a = 0; a < 32; a++)
      if (c_cnt[a] != ((a <= exp_len) ? 1 : 0)) bad++;
    check({tag, " addr_map"}, bad, 0);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " wren_overlap"}, overlap, 0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    int  snap;

    vecs[0] = '{key: 24'h4B6579, len: 8'd9, pt: 72'h506C61696E74657874,
                ct: 72'hBBF316E8D940AF0AD3, c0: 8'h09, ncheck: 9};
    vecs[1] = '{key: 24'h4B6579, len: 8'd9, pt: 72'h0,
                ct: 72'hEB9F7781B734CA72A7, c0: 8'h09, ncheck: 9};
    vecs[2] = '{key: 24'h4B6579, len: 8'd0, pt: 72'h0, ct: 72'h0, c0: 8'h00, ncheck: 0};
    vecs[3] = '{key: 24'h4B6579, len: 8'hFF, pt: 72'h010203040506070809,
                ct: 72'h0, c0: 8'h1F, ncheck: 0};

    reset = 1'b1;
    start = 1'b0;
    key   = '0;
    clr   = 1'b1;
    exp_len = 0;
    for (int a = 0; a < 32; a++) p_mem[a] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sWren", 32'(sWren), 32'd0);
    check("rst cWren", 32'(cWren), 32'd0);
    check("rst sAddr", 32'(sAddr), 32'd0);
    check("rst sIn", 32'(sIn), 32'd0);
    check("rst pAddr", 32'(pAddr), 32'd0);
    check("rst cAddr", 32'(cAddr), 32'd0);
    check("rst cIn", 32'(cIn), 32'd0);
    reset = 1'b0;
    clr   = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run_vec(vecs[v], 1'b0, 1'b0, cyc, seen);
      repeat (3) @(negedge clk);
      verify(vecs[v], cyc, seen, $sformatf("vec%0d", v));
    end

    // Abort in the middle of the key schedule, then rerun from scratch.
    load_mem(vecs[0]);
    key   = vecs[0].key;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    check("mid busy", 32'(busy), 32'd1);
    snap  = s_writes;
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort sWren", 32'(sWren), 32'd0);
    check("abort cWren", 32'(cWren), 32'd0);
    check("abort no s write", s_writes, snap);
    reset = 1'b0;
    @(negedge clk);
    check("abort idle", 32'(busy), 32'd0);
    run_vec(vecs[0], 1'b0, 1'b0, cyc, seen);
    repeat (3) @(negedge clk);
    verify(vecs[0], cyc, seen, "after_abort");

    // start held high and key changed after acceptance.
    run_vec(vecs[0], 1'b1, 1'b1, cyc, seen);
    @(negedge clk);
    check("held idle gap busy", 32'(busy), 32'd0);
    check("held idle gap done", 32'(done), 32'd0);
    @(negedge clk);
    check("held restart busy", 32'(busy), 32'd1);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    verify(vecs[0], cyc, seen, "held");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arcfour_encrypt.md
ARCFOUR_ENCRYPT -- requirements
Module: arcfour_encrypt

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, byte width of every memory word and key byte.
REQ-002 SHALL have parameter KEY_LENGTH, default 3, number of key bytes.
REQ-003 SHALL have parameter MESSAGE_LENGTH, default 32, words in plaintext/ciphertext memories (length word included).
REQ-004 SHALL have parameter MESSAGE_LOG_LENGTH, default 5, address width of plaintext/ciphertext memories.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  level; sampled only in IDLE.
REQ-008 SHALL have port key  input  KEY_LENGTH x RAM_WIDTH packed  key; byte b of key schedule = key[KEY_LENGTH-1-b]; captured when start is accepted.
REQ-009 SHALL have ports sAddr out 8, sIn out RAM_WIDTH, sWren out 1, sOut in RAM_WIDTH  S-box RAM with 1-cycle read latency.
REQ-010 SHALL have ports pAddr out MESSAGE_LOG_LENGTH, pOut in RAM_WIDTH  plaintext ROM with 1-cycle read latency.
REQ-011 SHALL have ports cAddr out MESSAGE_LOG_LENGTH, cIn out RAM_WIDTH, cWren out 1  ciphertext RAM write port.
REQ-012 SHALL have ports busy out 1 (high outside IDLE/DONE) and done out 1 (single-cycle pulse at completion).

Function
REQ-013 SHALL implement states IDLE, LOAD_LEN, INIT, SHUFFLE, [DROP], ENCRYPT, DONE; IDLE->LOAD_LEN on start=1; DONE->IDLE unconditionally after one cycle.
REQ-014 LOAD_LEN SHALL read pAddr=0 to obtain L; L SHALL be clamped to MESSAGE_LENGTH-1; clamped L SHALL be written unencrypted to cAddr=0.
REQ-015 INIT SHALL write S[i]=i for i=0..255, one write per cycle, exactly 256 cycles.
REQ-016 SHUFFLE SHALL, for i=0..255, compute j=(j+S[i]+key byte (i mod KEY_LENGTH)) mod 256 with j starting at 0, then swap S[i] and S[j]; all arithmetic 8-bit wrap-around.
REQ-017 Swap with i==j SHALL leave S[i] unchanged (second write uses value read before first write).
REQ-018 ENCRYPT SHALL reset i=j=0, then for k=1..L: i=i+1, j=j+S[i], swap, f=S[(S[i]+S[j]) mod 256], write cIn=pOut(k) XOR f at cAddr=k.
REQ-019 L=0 SHALL skip ENCRYPT; only the length word SHALL be written.
REQ-020 Total latency start-accept to done SHALL be <= 2 + 256 + 256*6 + L*8 + 4 cycles.
REQ-021 start while busy SHALL be ignored; key changes after acceptance SHALL not affect the operation.
REQ-022 sWren and cWren SHALL never both be high in the same cycle; each memory write SHALL last exactly one cycle.
REQ-023 Ciphertext addresses above L SHALL never be written.

Reset
REQ-024 On reset: state=IDLE, busy=0, done=0, sWren=0, cWren=0, sAddr=0, sIn=0, pAddr=0, cAddr=0, cIn=0, i=j=0.
REQ-025 Reset mid-operation SHALL abort within the reset cycle with no further memory writes; S RAM contents are then undefined.

Configuration
REQ-026 Macro ARCFOUR_ENCRYPT_DROP_EN: when defined, a DROP state between SHUFFLE and ENCRYPT SHALL generate and discard 256 keystream bytes (RC4-drop256), i/j/S carrying into ENCRYPT; latency bound grows by 256*6 cycles.
REQ-027 When ARCFOUR_ENCRYPT_DROP_EN is undefined, DROP SHALL not exist and SHUFFLE SHALL go directly to ENCRYPT (plain RC4, compatible with the existing decryptor).

Verification
REQ-028 key=24'h4B6579, plaintext L=9 "Plaintext" (50 6C 61 69 6E 74 65 78 74) -> c[0]=09, c[1..9]=BB F3 16 E8 D9 40 AF 0A D3, one done pulse.
REQ-029 key=24'h4B6579, L=9 all-zero plaintext -> c[1..9]=EB 9F 77 81 B7 34 CA 72 A7 (raw keystream).
REQ-030 L=0 -> only c[0]=00 written, done within 2+256+1536+4 cycles, no write to cAddr>=1.
REQ-031 p[0]=8'hFF with MESSAGE_LENGTH=32 -> c[0]=1F, 31 ciphertext bytes written, nothing beyond address 31.
REQ-032 reset asserted during SHUFFLE -> next cycle busy=0, all wren=0; new start with REQ-028 stimulus yields REQ-028 result.
REQ-033 start held high across run and key changed mid-run -> result equals REQ-028; second run begins only after IDLE is re-entered.
